// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared backend definitions: logical register index type and mul/div occupancy states.
// No logic; types and constants only.
// Imported by the hazard controller and its mul/div occupancy tracker.
package pipe_hazard_ctrl_pkg;

    localparam int LREG_W = 5;

    // Logical (architectural) register index range.
    typedef logic [LREG_W-1:0] lreg_t;

    // Mul/div occupancy of the EX stage.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_muldiv_occupancy.sv
// Tracks how long a multi-cycle mul/div keeps EX occupied.
// md_stall is combinational from state and md_req; state/cnt are registered.
// Once the op completes it parks in MD_DONE until EX actually advances, so it is never restarted.
module muldiv_occupancy
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic md_req,
    input  logic ex_advance,
    output logic md_start,
    output logic md_stall,
    output logic busy
);

    localparam int CW = $clog2(MULDIV_LAT);

    md_state_t       state;
    md_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    // State and remaining-cycle counter; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: start loads LAT-1 busy cycles; DONE waits for EX to drain.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_start  = 1'b0;
        md_stall  = 1'b0;
        busy      = (state != MD_IDLE);
        case (state)
            MD_IDLE: begin
                md_start = md_req;
                md_stall = md_req;
                if (md_req) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CW'(MULDIV_LAT - 1);
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                cnt_nxt  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                if (ex_advance) begin
                    state_nxt = MD_IDLE;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Backend hazard controller: per-stage stall/flush, redirect arbitration, stall perf counter.
// All stall/flush/redirect outputs are zero-latency combinational; only mul/div state and counter are registered.
// Memory waits freeze IF..MEM and bubble WB; a redirect is deferred while EX is stalled.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic             id_src1_is_reg,
    input  logic             id_src2_is_reg,
    input  lreg_t            id_rs1,
    input  lreg_t            id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_is_muldiv,
    input  lreg_t            ex_rd,
    input  logic             mem_req,
    input  logic             mem_done,
    input  logic             redirect_valid,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic             redirect_take,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic mem_stall;
    logic lu;
    logic md_start;
    logic md_stall;
    logic ex_advance;

    muldiv_occupancy #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_occupancy (
        .clock      (clock),
        .reset_n    (reset_n),
        .md_req     (ex_valid & ex_is_muldiv),
        .ex_advance (ex_advance),
        .md_start   (md_start),
        .md_stall   (md_stall),
        .busy       (muldiv_busy)
    );

    // Hazard terms and the stall/flush network; flush beats stall on the same register.
    always_comb begin
        mem_stall = mem_req & ~mem_done;
        lu = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
             ((id_src1_is_reg & (id_rs1 == ex_rd)) |
              (id_src2_is_reg & (id_rs2 == ex_rd)));

        stall_mem     = mem_stall;
        stall_ex      = mem_stall | md_stall;
        stall_id      = stall_ex | lu;
        // The ID instruction behind a mispredict is wrong-path, so redirect overrides load-use.
        redirect_take = redirect_valid & ~stall_ex;
        stall_if      = stall_id & ~redirect_take;
        flush_id      = redirect_take;
        flush_ex      = redirect_take | (lu & ~stall_ex);
        flush_mem     = md_stall & ~mem_stall;
        flush_wb      = mem_stall;
        ex_advance    = ~stall_ex;
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (stall_if && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       id_valid, id_src1_is_reg, id_src2_is_reg;
    lreg_t      id_rs1, id_rs2;
    logic       ex_valid, ex_is_load, ex_is_muldiv;
    lreg_t      ex_rd;
    logic       mem_req, mem_done, redirect_valid;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_mem, flush_wb;
    logic       redirect_take, muldiv_busy;
    logic [3:0] stall_cycles;

    pipe_hazard_ctrl #(
        .MULDIV_LAT (4),
        .CNT_W      (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_valid       (id_valid),
        .id_src1_is_reg (id_src1_is_reg),
        .id_src2_is_reg (id_src2_is_reg),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_is_muldiv   (ex_is_muldiv),
        .ex_rd          (ex_rd),
        .mem_req        (mem_req),
        .mem_done       (mem_done),
        .redirect_valid (redirect_valid),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .flush_mem      (flush_mem),
        .flush_wb       (flush_wb),
        .redirect_take  (redirect_take),
        .muldiv_busy    (muldiv_busy),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs, bit order:
    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, redirect_take, muldiv_busy}
    typedef struct packed {
        logic [9:0] outs;
        logic [3:0] cnt;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [3:0] exp_cnt = 4'd0;

    // Monitor: one expectation per cycle, compared on the falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = q.pop_front();
            act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                   flush_mem, flush_wb, redirect_take, muldiv_busy};
            n_vec++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL outs vec%0d: got %b expected %b", e.id, act, e.outs);
            end
            n_vec++;
            if (stall_cycles !== e.cnt) begin
                n_fail++;
                $display("FAIL stall_cycles vec%0d: got %0d expected %0d", e.id, stall_cycles, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_src1_is_reg = 0; id_src2_is_reg = 0;
        id_rs1 = '0; id_rs2 = '0;
        ex_valid = 0; ex_is_load = 0; ex_is_muldiv = 0; ex_rd = '0;
        mem_req = 0; mem_done = 0; redirect_valid = 0;
    endtask

    task automatic load_use(input lreg_t rd, input logic s1, input lreg_t r1,
                            input logic s2, input lreg_t r2);
        id_valid = 1; id_src1_is_reg = s1; id_rs1 = r1;
        id_src2_is_reg = s2; id_rs2 = r2;
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    endtask

    task automatic md_in();
        ex_valid = 1; ex_is_muldiv = 1;
    endtask

    // Push the expectation for the current cycle; the counter value seen now
    // reflects only earlier cycles' stall_if.
    task automatic expect_o(input logic [9:0] e, input int id);
        exp_t x;
        if (!reset_n) exp_cnt = 4'd0;
        x.outs = e;
        x.cnt  = exp_cnt;
        x.id   = id;
        q.push_back(x);
        if (reset_n && e[9] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    initial begin
        reset_n = 0;
        clr();
        // Reset state
        tick(); expect_o(10'b0000000000, 0);
        tick(); reset_n = 1; clr(); expect_o(10'b0000000000, 1);

        // Load x5 in EX, add x6,x5,x1 in ID
        tick(); clr(); load_use(5'd5, 1, 5'd5, 1, 5'd1); expect_o(10'b1100010000, 2);
        tick(); clr(); id_valid = 1; id_src1_is_reg = 1; id_rs1 = 5'd5; expect_o(10'b0000000000, 3);
        // ex_rd = 0 never hazards
        tick(); clr(); load_use(5'd0, 1, 5'd0, 1, 5'd0); expect_o(10'b0000000000, 4);
        // rs2 match ignored when src2 is not a register, detected when it is
        tick(); clr(); load_use(5'd7, 1, 5'd3, 0, 5'd7); expect_o(10'b0000000000, 5);
        tick(); clr(); load_use(5'd7, 1, 5'd3, 1, 5'd7); expect_o(10'b1100010000, 6);

        // Mul/div, LAT 4: stall cycles 0..3, free at 4, idle at 5
        tick(); clr(); md_in(); expect_o(10'b1110001000, 10);
        for (int i = 0; i < 3; i++) begin
            tick(); clr(); md_in(); expect_o(10'b1110001001, 11 + i);
        end
        tick(); clr(); md_in(); expect_o(10'b0000000001, 14);
        tick(); clr(); expect_o(10'b0000000000, 15);

        // Memory wait of 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); clr(); mem_req = 1; expect_o(10'b1111000100, 20 + i);
        end
        tick(); clr(); mem_req = 1; mem_done = 1; expect_o(10'b0000000000, 23);

        // Redirect with load-use: redirect wins, IF not held
        tick(); clr(); load_use(5'd5, 1, 5'd5, 0, 5'd0); redirect_valid = 1; expect_o(10'b0100110010, 30);
        // Redirect deferred by memory wait
        for (int i = 0; i < 2; i++) begin
            tick(); clr(); mem_req = 1; redirect_valid = 1; expect_o(10'b1111000100, 31 + i);
        end
        tick(); clr(); mem_req = 1; mem_done = 1; redirect_valid = 1; expect_o(10'b0000110010, 33);

        // Mul/div under a long memory wait: no flush_mem, parks in MD_DONE
        tick(); clr(); md_in(); mem_req = 1; expect_o(10'b1111000100, 40);
        for (int i = 0; i < 5; i++) begin
            tick(); clr(); md_in(); mem_req = 1; expect_o(10'b1111000101, 41 + i);
        end
        tick(); clr(); md_in(); mem_req = 1; mem_done = 1; expect_o(10'b0000000001, 46);
        tick(); clr(); expect_o(10'b0000000000, 47);

        // Further stalls keep the counter saturated at 15
        for (int i = 0; i < 5; i++) begin
            tick(); clr(); mem_req = 1; expect_o(10'b1111000100, 50 + i);
        end
        tick(); clr(); expect_o(10'b0000000000, 55);

        // Reset asserted mid-MD_BUSY aborts immediately
        tick(); clr(); md_in(); expect_o(10'b1110001000, 60);
        tick(); clr(); md_in(); expect_o(10'b1110001001, 61);
        tick(); clr(); reset_n = 0; expect_o(10'b0000000000, 62);
        tick(); reset_n = 1; clr(); expect_o(10'b0000000000, 63);
        tick(); clr(); load_use(5'd9, 0, 5'd0, 1, 5'd9); expect_o(10'b1100010000, 64);
        tick(); clr(); expect_o(10'b0000000000, 65);

        @(negedge clock);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central backend hazard controller. It generates the per-stage `stall` and `redirect_flush` inputs consumed by the pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- It detects load-use hazards, tracks multi-cycle mul/div occupancy of EX with a small FSM, and freezes the pipe on outstanding memory accesses.
- It arbitrates a branch redirect from EX into flushes.
- It keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `MULDIV_LAT`, default 4: cycles EX is stalled per mul/div; legal range ≥2.
- `CNT_W`, default 32: width of the stall performance counter.

Ports:
- `clock` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_valid`, `id_src1_is_reg`, `id_src2_is_reg` in 1 each: ID-stage instruction info.
- `id_rs1`, `id_rs2` in `LREG_RANGE`: ID source registers.
- `ex_valid`, `ex_is_load`, `ex_is_muldiv` in 1 each: EX-stage instruction info.
- `ex_rd` in `LREG_RANGE`: EX destination register.
- `mem_req` in 1: valid load/store occupying MEM.
- `mem_done` in 1: memory response for that access this cycle.
- `redirect_valid` in 1: branch/jump in EX resolved mispredicted.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem` out 1: hold the register feeding the named stage (IF = PC register).
- `flush_id`, `flush_ex`, `flush_mem`, `flush_wb` out 1: clear the register feeding the named stage; a bubble.
- `redirect_take` out 1: IF loads the redirect PC this cycle.
- `muldiv_busy` out 1: mul/div FSM not `MD_IDLE`.
- `stall_cycles` out `CNT_W`: saturating count of `stall_if` cycles.

## Operation
Combinational terms:
- `mem_stall = mem_req & ~mem_done`.
- `lu = id_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((id_src1_is_reg & id_rs1 == ex_rd) | (id_src2_is_reg & id_rs2 == ex_rd))`.
- `md_start = (state == MD_IDLE) & ex_valid & ex_is_muldiv`.
- `md_stall = md_start | (state == MD_BUSY)`.

Outputs:
- `stall_mem = mem_stall`.
- `stall_ex = mem_stall | md_stall`.
- `stall_id = stall_ex | lu`.
- `redirect_take = redirect_valid & ~stall_ex`.
- `stall_if = stall_id & ~redirect_take`.
- `flush_id = redirect_take`.
- `flush_ex = redirect_take | (lu & ~stall_ex)`.
- `flush_mem = md_stall & ~mem_stall`.
- `flush_wb = mem_stall`.

Priority rules:
- A register that receives both flush and stall clears; flush wins.
- Redirect overrides the load-use stall, because the ID instruction is wrong-path.
- A redirect during `stall_ex` is deferred. EX holds the branch, so `redirect_valid` re-presents until taken.

Mul/div FSM, states `MD_IDLE`, `MD_BUSY`, `MD_DONE`, with down-counter `cnt` of width `$clog2(MULDIV_LAT)`:
- `MD_IDLE` → `MD_BUSY` on `md_start`, loading `cnt = MULDIV_LAT-1`.
- `MD_BUSY`: decrement `cnt`; at `cnt == 1` go to `MD_DONE`.
- `MD_DONE`: contributes no stall. Go to `MD_IDLE` on the first cycle with `stall_ex == 0`, i.e. the instruction leaves EX; the same instruction is never restarted.
- The counter keeps running during `mem_stall`.

Performance counter: `stall_cycles` increments each cycle `stall_if == 1` and saturates at all-ones.

## Timing
- All stall, flush and redirect outputs are combinational from inputs and state, with zero-cycle latency. Only the FSM, `cnt` and `stall_cycles` are registered.
- Reset: state `MD_IDLE`, `cnt` 0, `stall_cycles` 0, `muldiv_busy` 0. With all inputs 0, every output is 0.
- Reset asserted mid-mul/div aborts it immediately (asynchronous).
- A mul/div holds `stall_ex` for exactly `MULDIV_LAT` consecutive cycles: the start cycle plus `MULDIV_LAT-1` cycles in `MD_BUSY`. EX advances on the next edge unless `mem_stall` is active.
- Load-use inserts exactly one bubble into EX; ID/IF are held one cycle, or longer while `stall_ex` persists.
- A memory wait stalls IF..MEM and bubbles WB every cycle until `mem_done`. `mem_req & mem_done` in the same cycle produces no stall.

## Structure
- `LREG_RANGE` and the `md_state_t` enum belong in the shared backend package/defines.
- Sub-module `muldiv_occupancy` holds the FSM and `cnt`, with I/O `md_start`, `ex_advance`, `md_stall`, `busy`. Everything else is flat combinational logic plus the counter.

## Test plan
- Load x5 in EX, ID `add x6,x5,x1` (rs1 reg) → `stall_if = stall_id = flush_ex = 1` for 1 cycle; next cycle all 0. Same stimulus with `ex_rd = 0` → no stall.
- `ex_is_muldiv = 1`, `MULDIV_LAT = 4` → `stall_ex`/`flush_mem` high for cycles 0–3, low at cycle 4, `muldiv_busy` low at cycle 5; no restart while the instruction remains in EX.
- `mem_req = 1`, `mem_done` after 3 cycles → `stall_if..stall_mem` and `flush_wb` high for 3 cycles. With a mul/div concurrent, `flush_mem` stays 0 during `mem_stall`, and the FSM waits in `MD_DONE` until the stall releases.
- `redirect_valid` together with load-use → `redirect_take = flush_id = flush_ex = 1`, `stall_if = 0`. Redirect during `mem_stall` → `redirect_take = 0` until `mem_done`.
- 2^`CNT_W` + 5 stall cycles with `CNT_W = 4` → `stall_cycles` saturates at 15. `reset_n` low mid-`MD_BUSY` → state `MD_IDLE`, counter 0, outputs 0.
